// File: rtl/mem_access_ctrl.sv
// Initiator for the small register-file memory: turns single/burst commands into
// setup/strobe/hold write cycles and addressed, settled read samples.
module mem_access_ctrl #(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 2,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              cmd_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dbus,
  output logic              mem_rwb,
  input  logic [DATA_W-1:0] mem_qout
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] W_WAIT   = 3'd1;
  localparam logic [2:0] W_SETUP  = 3'd2;
  localparam logic [2:0] W_STROBE = 3'd3;
  localparam logic [2:0] W_HOLD   = 3'd4;
  localparam logic [2:0] R_ADDR   = 3'd5;
  localparam logic [2:0] R_SAMPLE = 3'd6;
  localparam logic [2:0] R_OUT    = 3'd7;

  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  logic [2:0]        state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic              burst_reg;
  logic              last_beat;

  assign last_beat = !burst_reg || (cnt_reg == LAST_BEAT);

  // Every output is a register loaded alongside the state it belongs to, so the
  // memory pins never see decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      burst_reg   <= 1'b0;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      cmd_done    <= 1'b0;
      mem_rwb     <= 1'b0;
      mem_addr    <= '0;
      mem_dbus    <= '0;
      rdata       <= '0;
    end else begin
      cmd_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            burst_reg <= cmd_op[1];
            ptr_reg   <= cmd_addr;
            cnt_reg   <= '0;
            case (cmd_op)
              2'b01: begin
                mem_dbus  <= cmd_data;
                mem_addr  <= cmd_addr;
                state_reg <= W_SETUP;
              end
              2'b11: begin
                wdata_ready <= 1'b1;
                state_reg   <= W_WAIT;
              end
              default: begin
                mem_addr  <= cmd_addr;
                state_reg <= R_ADDR;
              end
            endcase
          end
        end
        W_WAIT: begin
          if (wdata_valid && wdata_ready) begin
            wdata_ready <= 1'b0;
            mem_dbus    <= wdata;
            mem_addr    <= ptr_reg;
            state_reg   <= W_SETUP;
          end
        end
        W_SETUP: begin
          mem_rwb   <= 1'b1;
          state_reg <= W_STROBE;
        end
        W_STROBE: begin
          mem_rwb   <= 1'b0;
          cmd_done  <= last_beat;
          state_reg <= W_HOLD;
        end
        W_HOLD: begin
          if (last_beat) begin
            cmd_ready <= 1'b1;
            state_reg <= IDLE;
          end else begin
            ptr_reg     <= ptr_reg + ONE;
            cnt_reg     <= cnt_reg + ONE;
            wdata_ready <= 1'b1;
            state_reg   <= W_WAIT;
          end
        end
        R_ADDR: begin
          state_reg <= R_SAMPLE;
        end
        R_SAMPLE: begin
          rdata       <= mem_qout;
          rdata_valid <= 1'b1;
          state_reg   <= R_OUT;
        end
        R_OUT: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            if (last_beat) begin
              cmd_done  <= 1'b1;
              cmd_ready <= 1'b1;
              state_reg <= IDLE;
            end else begin
              ptr_reg   <= ptr_reg + ONE;
              cnt_reg   <= cnt_reg + ONE;
              mem_addr  <= ptr_reg + ONE;
              state_reg <= R_ADDR;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a strobe-latched memory model plus a reference
// memory image predicts every write strobe and every read beat.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  localparam int BURST_LEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_addr = 2'b00;
  logic [3:0] cmd_data = 4'h0;
  logic       wdata_valid = 1'b0;
  logic       wdata_ready;
  logic [3:0] wdata = 4'h0;
  logic       rdata_valid;
  logic       rdata_ready = 1'b0;
  logic [3:0] rdata;
  logic       cmd_done;
  logic [1:0] mem_addr;
  logic [3:0] mem_dbus;
  logic       mem_rwb;
  logic [3:0] mem_qout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_W(4), .ADDR_W(2), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .cmd_done(cmd_done),
    .mem_addr(mem_addr), .mem_dbus(mem_dbus), .mem_rwb(mem_rwb), .mem_qout(mem_qout)
  );

  // Register-file memory: latches on strobe, reads combinationally.
  logic [3:0] mem_arr [4];
  always @(posedge clk) if (mem_rwb) mem_arr[mem_addr] <= mem_dbus;
  assign mem_qout = mem_arr[mem_addr];

  // Bus monitor: logs strobes, counts done pulses, and flags address/data
  // movement next to a strobe or a strobe longer than one cycle.
  logic [1:0] strobe_addr [$];
  logic [3:0] strobe_data [$];
  int         done_cnt = 0;
  int         viol = 0;
  logic       rst_at_edge = 1'b1;
  logic [1:0] prev_addr = 2'b00;
  logic [3:0] prev_dbus = 4'h0;
  logic       prev_rwb = 1'b0;

  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    if (cmd_done) done_cnt <= done_cnt + 1;
    if (mem_rwb) begin
      strobe_addr.push_back(mem_addr);
      strobe_data.push_back(mem_dbus);
    end
    if (!rst_at_edge &&
        ((mem_rwb && (prev_rwb || mem_addr != prev_addr || mem_dbus != prev_dbus)) ||
         (prev_rwb && !mem_rwb && (mem_addr != prev_addr || mem_dbus != prev_dbus))))
      viol <= viol + 1;
    prev_addr <= mem_addr;
    prev_dbus <= mem_dbus;
    prev_rwb  <= mem_rwb;
  end

  logic [3:0] ref_mem [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [3:0] data);
    int w;
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    check("cmd_accept_wait", w < 50, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    check("idle_wait", w < 50, 1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [15:0] wvals,
                         input int gap_lo, input int gap_hi, input int stall_lo, input int stall_hi,
                         input bit pre_ready);
    int n, done_before, w, stall, nstrobe;
    logic [1:0] a;
    logic [3:0] exp_d;
    n = op[1] ? BURST_LEN : 1;
    done_before = done_cnt;
    strobe_addr.delete();
    strobe_data.delete();
    rdata_ready = pre_ready;
    send_cmd(op, addr, wvals[3:0]);
    for (int i = 0; i < n; i++) begin
      a = addr + 2'(i);
      if (op[0]) begin
        exp_d = wvals[4*i +: 4];
        if (op[1]) begin
          repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
          wdata = exp_d; wdata_valid = 1'b1;
          w = 0;
          while (!wdata_ready && w < 50) begin @(negedge clk); w++; end
          check("wbeat_wait", w < 50, 1);
          @(negedge clk);
          wdata_valid = 1'b0;
        end
        ref_mem[a] = exp_d;
      end else begin
        exp_d = ref_mem[a];
        w = 0;
        while (!rdata_valid && w < 50) begin @(negedge clk); w++; end
        check("rbeat_wait", w < 50, 1);
        check("rdata", rdata, exp_d);
        if (!pre_ready) begin
          stall = $urandom_range(stall_hi, stall_lo);
          for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("rdata_hold", {rdata_valid, rdata}, {1'b1, exp_d});
          end
          rdata_ready = 1'b1;
        end
        @(negedge clk);
        rdata_ready = pre_ready;
        check("rvalid_clear", rdata_valid, 0);
      end
    end
    wait_idle();
    @(negedge clk);
    rdata_ready = 1'b0;
    check("done_count", done_cnt - done_before, 1);
    if (op[0]) begin
      nstrobe = strobe_addr.size();
      check("strobe_count", nstrobe, n);
      for (int i = 0; i < n && i < nstrobe; i++) begin
        a = addr + 2'(i);
        check("strobe_addr", strobe_addr[i], a);
        check("strobe_data", strobe_data[i], wvals[4*i +: 4]);
      end
    end
    check("bus_stability", viol, 0);
    $display("txn op=%0d addr=%0d wvals=%04h checks=%0d errors=%0d", op, addr, wvals, checks, errors);
  endtask

  initial begin
    int done_before, w;
    logic [1:0] r_op, r_addr;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_outputs", {wdata_ready, rdata_valid, cmd_done, mem_rwb}, 4'b0000);
    check("rst_buses", {mem_addr, mem_dbus, rdata}, 10'h000);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);

    // Single write addr 2 data A with cycle-exact phases
    done_before = done_cnt;
    strobe_addr.delete(); strobe_data.delete();
    send_cmd(2'b01, 2'd2, 4'hA);
    check("sw_c1_setup", {mem_rwb, mem_addr, mem_dbus, cmd_ready}, {1'b0, 2'd2, 4'hA, 1'b0});
    @(negedge clk);
    check("sw_c2_strobe", {mem_rwb, mem_addr, mem_dbus}, {1'b1, 2'd2, 4'hA});
    @(negedge clk);
    check("sw_c3_hold", {mem_rwb, mem_addr, mem_dbus, cmd_done}, {1'b0, 2'd2, 4'hA, 1'b1});
    @(negedge clk);
    check("sw_c4_ready", {cmd_ready, cmd_done}, 2'b10);
    ref_mem[2] = 4'hA;
    $display("txn single write addr=2 data=a");

    // Single read addr 2
    send_cmd(2'b00, 2'd2, 4'h0);
    check("sr_c1", {rdata_valid, mem_addr, mem_rwb}, {1'b0, 2'd2, 1'b0});
    @(negedge clk);
    check("sr_c2", rdata_valid, 0);
    @(negedge clk);
    check("sr_c3", {rdata_valid, rdata}, {1'b1, 4'hA});
    rdata_ready = 1'b1;
    @(negedge clk);
    rdata_ready = 1'b0;
    check("sr_clear", rdata_valid, 0);
    @(negedge clk);
    check("single_done_count", done_cnt - done_before, 2);
    check("single_strobes", strobe_addr.size(), 1);
    $display("txn single read addr=2 data=%0h", rdata);

    // Burst write from 3 with gapped beats, then stalled and pre-ready burst reads
    run_cmd(2'b11, 2'd3, 16'h4321, 5, 5, 0, 0, 1'b0);
    run_cmd(2'b10, 2'd1, 16'h0000, 0, 0, 3, 3, 1'b0);
    run_cmd(2'b10, 2'd3, 16'h0000, 0, 0, 0, 0, 1'b1);

    // cmd_valid held high across a write: next command waits for cycle 4
    done_before = done_cnt;
    strobe_addr.delete(); strobe_data.delete();
    cmd_op = 2'b01; cmd_addr = 2'd1; cmd_data = 4'h5; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    check("hold_accept_wait", w < 50, 1);
    @(negedge clk);
    cmd_op = 2'b00;
    check("hold_c1_ready", cmd_ready, 0);
    @(negedge clk);
    check("hold_c2", {cmd_ready, mem_rwb}, 2'b01);
    @(negedge clk);
    check("hold_c3_ready", cmd_ready, 0);
    @(negedge clk);
    check("hold_c4_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("hold_c5", {cmd_ready, mem_rwb, mem_addr}, {1'b0, 1'b0, 2'd1});
    ref_mem[1] = 4'h5;
    rdata_ready = 1'b1;
    w = 0;
    while (!rdata_valid && w < 50) begin @(negedge clk); w++; end
    check("hold_read_wait", w < 50, 1);
    check("hold_rdata", rdata, 4'h5);
    @(negedge clk);
    rdata_ready = 1'b0;
    wait_idle();
    @(negedge clk);
    check("hold_done_count", done_cnt - done_before, 2);
    check("hold_strobes", strobe_addr.size(), 1);
    $display("txn held-valid write then read addr=1");

    // Reset during the strobe of beat 2 of a burst write from 0
    done_before = done_cnt;
    send_cmd(2'b11, 2'd0, 4'h0);
    wdata = 4'h9; wdata_valid = 1'b1;
    w = 0;
    while (!wdata_ready && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    wdata_valid = 1'b0;
    while (!wdata_ready && w < 50) begin @(negedge clk); w++; end
    wdata = 4'h6; wdata_valid = 1'b1;
    @(negedge clk);
    wdata_valid = 1'b0;
    while (!mem_rwb && w < 50) begin @(negedge clk); w++; end
    check("rst_test_wait", w < 50, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rwb", mem_rwb, 0);
    check("midrst_outputs", {cmd_ready, wdata_ready, rdata_valid, cmd_done}, 4'b0000);
    check("midrst_buses", {mem_addr, mem_dbus, rdata}, 10'h000);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", {cmd_ready, wdata_ready}, 2'b10);
    check("midrst_no_done", done_cnt - done_before, 0);
    ref_mem[0] = 4'h9;
    ref_mem[1] = 4'h6;
    $display("txn burst write aborted by reset at beat 2");
    run_cmd(2'b10, 2'd0, 16'h0000, 0, 0, 0, 1, 1'b0);

    // Randomized commands against the reference memory image
    for (int t = 0; t < 20; t++) begin
      r_op = 2'($urandom_range(3, 0));
      r_addr = 2'($urandom_range(3, 0));
      run_cmd(r_op, r_addr, 16'($urandom), 0, 6, 0, 3, 1'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
